// File: rtl/counter_sequencer_pkg.sv
// Shared types for the counter sequencer: typed FSM states and run-mode constants.
// Latency: n/a (types only).
// Backpressure: n/a.
package counter_sequencer_pkg;
`include "cnt_seq_defs.vh"

   localparam int unsigned STATE_W = `CNT_SEQ_STATE_W;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = `CNT_SEQ_ST_IDLE,
      S_ARMED = `CNT_SEQ_ST_ARMED,
      S_RUN   = `CNT_SEQ_ST_RUN,
      S_HOLD  = `CNT_SEQ_ST_HOLD,
      S_DONE  = `CNT_SEQ_ST_DONE
   } state_e;

   localparam logic MODE_ONESHOT  = `MODE_ONESHOT;
   localparam logic MODE_PERIODIC = `MODE_PERIODIC;

endpackage

// File: rtl/cnt_core.sv
// Counter datapath: WIDTH-bit up-counter with clear/enable and terminal compare.
// Latency: count updates one edge after clr/en; term is combinational on count.
// Backpressure: none; the sequencer decides every cycle whether to clear, count or hold.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr, en       clear has priority over enable; neither -> hold
//   limit         terminal value compared against the current count
//   count, term   registered count, (count == limit)
module cnt_core
   import counter_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             term
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         // The sequencer never enables at limit, so this cannot wrap.
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign term  = (count_q == limit);

endmodule

// File: rtl/cnt_seq_defs.vh
// Shared encodings for the counter sequencer: FSM state codes, state width, run modes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
`ifndef CNT_SEQ_DEFS_VH
`define CNT_SEQ_DEFS_VH

`define CNT_SEQ_STATE_W   3
`define CNT_SEQ_ST_IDLE   3'd0
`define CNT_SEQ_ST_ARMED  3'd1
`define CNT_SEQ_ST_RUN    3'd2
`define CNT_SEQ_ST_HOLD   3'd3
`define CNT_SEQ_ST_DONE   3'd4

`define MODE_ONESHOT      1'b0
`define MODE_PERIODIC     1'b1

`endif

// File: rtl/counter_sequencer.sv
// One-shot/periodic timer sequencer around a WIDTH-bit counter (FSM, config regs, tc/done).
// Latency: config accepted in one edge; count=1 two edges after start; tc one edge after terminal.
// Backpressure: cfg_ready low in ARMED/RUN/HOLD; offered configs there are dropped, not queued.
// Optional feature: CNT_SEQ_PERIODIC_EN enables periodic mode; otherwise cfg_mode is ignored.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cfg_valid/cfg_ready              config handshake carrying cfg_period, cfg_mode
//   start, halt                      begin/resume and pause requests (halt wins when both)
//   count, tc                        registered count, one-cycle terminal-count pulse
//   busy, done                       RUN/HOLD indicator, DONE level
module counter_sequencer
   import counter_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_period,
   input  logic             cfg_mode,
   input  logic             start,
   input  logic             halt,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             tc_q, tc_d;
   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_term;

`ifdef CNT_SEQ_PERIODIC_EN
   logic             mode_q, mode_d;
`else
   logic             mode_q;
   logic             unused_cfg_mode;
   assign mode_q          = MODE_ONESHOT;
   assign unused_cfg_mode = cfg_mode;
`endif

   cnt_core #(
      .WIDTH (WIDTH)
   ) u_cnt_core (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .limit (period_q),
      .count (count),
      .term  (cnt_term)
   );

   // State and config registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         period_q <= '0;
         tc_q     <= 1'b0;
`ifdef CNT_SEQ_PERIODIC_EN
         mode_q   <= MODE_ONESHOT;
`endif
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         tc_q     <= tc_d;
`ifdef CNT_SEQ_PERIODIC_EN
         mode_q   <= mode_d;
`endif
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      period_d = period_q;
`ifdef CNT_SEQ_PERIODIC_EN
      mode_d   = mode_q;
`endif
      tc_d     = 1'b0;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cfg_valid) begin
               period_d = cfg_period;
`ifdef CNT_SEQ_PERIODIC_EN
               mode_d   = cfg_mode;
`endif
               cnt_clr  = 1'b1;
               state_d  = S_ARMED;
            end
         end
         S_ARMED: begin
            if (start) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // The terminal action takes precedence over a simultaneous halt.
            if (cnt_term) begin
               tc_d = 1'b1;
`ifdef CNT_SEQ_PERIODIC_EN
               if (mode_q == MODE_PERIODIC) begin
                  cnt_clr = 1'b1;
                  state_d = halt ? S_HOLD : S_RUN;
               end else begin
                  state_d = S_DONE;
               end
`else
               state_d = S_DONE;
`endif
            end else if (halt) begin
               state_d = S_HOLD;
            end else begin
               cnt_en = 1'b1;
            end
         end
         S_HOLD: begin
            if (start && !halt) begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            // A new config outranks a restart with the old one.
            if (cfg_valid) begin
               period_d = cfg_period;
`ifdef CNT_SEQ_PERIODIC_EN
               mode_d   = cfg_mode;
`endif
               cnt_clr  = 1'b1;
               state_d  = S_ARMED;
            end else if (start) begin
               cnt_clr = 1'b1;
               state_d = S_RUN;
            end
         end
         default: begin
            // Unused encodings recover to IDLE with a clean counter.
            cnt_clr = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      cfg_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE:  cfg_ready = 1'b1;
         S_DONE: begin
            cfg_ready = 1'b1;
            done      = 1'b1;
         end
         S_RUN, S_HOLD: busy = 1'b1;
         default: ;
      endcase
   end

   assign tc = tc_q;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;
   logic       clk;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [3:0] cfg_period;
   logic       cfg_mode;
   logic       start;
   logic       halt;
   logic [3:0] count;
   logic       tc;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   counter_sequencer #(.WIDTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_period (cfg_period),
      .cfg_mode   (cfg_mode),
      .start      (start),
      .halt       (halt),
      .count      (count),
      .tc         (tc),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic do_cfg(input logic [3:0] p, input logic m);
      cfg_valid  = 1'b1;
      cfg_period = p;
      cfg_mode   = m;
      tick();
      cfg_valid  = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b want 0", tc); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
   endtask

   task automatic test_oneshot();
      do_reset();
      do_cfg(4'd5, 1'b0);
      n_checks++; if (cfg_ready !== 1'b0 || busy !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL oneshot_armed: got rdy=%b busy=%b cnt=%0d want rdy=0 busy=0 cnt=0", cfg_ready, busy, count); end
      // halt in ARMED is ignored
      halt = 1'b1; start = 1'b1; tick(); halt = 1'b0; start = 1'b0;
      n_checks++; if (busy !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL oneshot_start: got busy=%b cnt=%0d want busy=1 cnt=0", busy, count); end
      for (int i = 1; i <= 5; i++) begin
         tick();
         n_checks++; if (count !== 4'(i) || tc !== 1'b0) begin n_fail++; $display("FAIL oneshot_count: got cnt=%0d tc=%b want cnt=%0d tc=0", count, tc, i); end
      end
      // terminal edge with halt: one-shot still goes to DONE
      halt = 1'b1; tick(); halt = 1'b0;
      n_checks++; if (tc !== 1'b1 || done !== 1'b1 || count !== 4'd5 || busy !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL oneshot_term: got tc=%b done=%b cnt=%0d busy=%b rdy=%b want 1 1 5 0 1", tc, done, count, busy, cfg_ready); end
      tick();
      n_checks++; if (tc !== 1'b0 || done !== 1'b1 || count !== 4'd5) begin n_fail++; $display("FAIL oneshot_hold: got tc=%b done=%b cnt=%0d want 0 1 5", tc, done, count); end
   endtask

   task automatic test_periodic();
      do_reset();
      do_cfg(4'd3, 1'b1);
      do_start();
`ifdef CNT_SEQ_PERIODIC_EN
      for (int j = 1; j <= 15; j++) begin
         tick();
         n_checks++; if (count !== 4'(j % 4) || tc !== (j % 4 == 0) || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL periodic_seq%0d: got cnt=%0d tc=%b busy=%b want cnt=%0d tc=%0d busy=1", j, count, tc, busy, j % 4, j % 4 == 0); end
      end
      // terminal + halt: wraps to 0 and parks in HOLD
      halt = 1'b1; tick();
      n_checks++; if (count !== 4'd0 || tc !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL periodic_term_halt: got cnt=%0d tc=%b busy=%b want 0 1 1", count, tc, busy); end
      tick(); halt = 1'b0;
      n_checks++; if (count !== 4'd0 || tc !== 1'b0) begin n_fail++; $display("FAIL periodic_hold: got cnt=%0d tc=%b want 0 0", count, tc); end
`else
      // periodic request is treated as one-shot
      for (int j = 1; j <= 3; j++) begin
         tick();
         n_checks++; if (count !== 4'(j)) begin n_fail++; $display("FAIL nomode_count: got %0d want %0d", count, j); end
      end
      tick();
      n_checks++; if (tc !== 1'b1 || done !== 1'b1 || count !== 4'd3) begin n_fail++; $display("FAIL nomode_term: got tc=%b done=%b cnt=%0d want 1 1 3", tc, done, count); end
      tick();
      n_checks++; if (tc !== 1'b0 || count !== 4'd3) begin n_fail++; $display("FAIL nomode_after: got tc=%b cnt=%0d want 0 3", tc, count); end
`endif
   endtask

   task automatic test_halt();
      do_reset();
      do_cfg(4'd5, 1'b0);
      do_start();
      tick(); tick();
      n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL halt_pre: got %0d want 2", count); end
      halt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (count !== 4'd2 || busy !== 1'b1 || tc !== 1'b0) begin n_fail++; $display("FAIL halt_frozen: got cnt=%0d busy=%b tc=%b want 2 1 0", count, busy, tc); end
      end
      halt = 1'b0;
      do_start();
      n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL halt_resume_edge: got %0d want 2", count); end
      tick();
      n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL halt_resumed: got %0d want 3", count); end
      halt = 1'b1; start = 1'b1;
      tick(); tick();
      n_checks++; if (count !== 4'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL halt_start_both: got cnt=%0d busy=%b want 3 1", count, busy); end
      halt = 1'b0;
      tick(); start = 1'b0;
      tick();
      n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL halt_release: got %0d want 4", count); end
   endtask

   task automatic test_cfg_handshake();
      do_reset();
      do_cfg(4'd2, 1'b0);
      do_start();
      cfg_valid = 1'b1; cfg_period = 4'd9; cfg_mode = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         tick();
         n_checks++; if (cfg_ready !== 1'b0 || count !== 4'(i)) begin n_fail++; $display("FAIL cfg_run_ignored: got rdy=%b cnt=%0d want 0 %0d", cfg_ready, count, i); end
      end
      tick();
      cfg_valid = 1'b0;
      n_checks++; if (tc !== 1'b1 || done !== 1'b1 || count !== 4'd2) begin n_fail++; $display("FAIL cfg_period_kept: got tc=%b done=%b cnt=%0d want 1 1 2", tc, done, count); end
      // cfg + start in DONE: config wins -> ARMED
      cfg_valid = 1'b1; cfg_period = 4'd1; start = 1'b1;
      tick();
      cfg_valid = 1'b0; start = 1'b0;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL cfg_done_armed: got busy=%b done=%b rdy=%b cnt=%0d want 0 0 0 0", busy, done, cfg_ready, count); end
      do_start();
      tick(); tick();
      n_checks++; if (tc !== 1'b1 || done !== 1'b1 || count !== 4'd1) begin n_fail++; $display("FAIL cfg_new_period: got tc=%b done=%b cnt=%0d want 1 1 1", tc, done, count); end
      // start alone in DONE reruns with the same config
      do_start();
      n_checks++; if (busy !== 1'b1 || done !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL done_restart: got busy=%b done=%b cnt=%0d want 1 0 0", busy, done, count); end
      tick(); tick();
      n_checks++; if (tc !== 1'b1 || count !== 4'd1) begin n_fail++; $display("FAIL done_rerun: got tc=%b cnt=%0d want 1 1", tc, count); end
   endtask

   task automatic test_period_bounds();
      do_reset();
      do_cfg(4'd0, 1'b0);
      do_start();
      tick();
      n_checks++; if (tc !== 1'b1 || done !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL zero_oneshot: got tc=%b done=%b cnt=%0d want 1 1 0", tc, done, count); end
`ifdef CNT_SEQ_PERIODIC_EN
      do_reset();
      do_cfg(4'd0, 1'b1);
      do_start();
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (tc !== 1'b1 || count !== 4'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL zero_periodic: got tc=%b cnt=%0d busy=%b want 1 0 1", tc, count, busy); end
      end
`endif
      do_reset();
      do_cfg(4'd15, 1'b0);
      do_start();
      for (int i = 1; i <= 15; i++) tick();
      n_checks++; if (count !== 4'd15 || tc !== 1'b0) begin n_fail++; $display("FAIL max_reach: got cnt=%0d tc=%b want 15 0", count, tc); end
      tick();
      n_checks++; if (count !== 4'd15 || tc !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL max_term: got cnt=%0d tc=%b done=%b want 15 1 1", count, tc, done); end
      tick();
      n_checks++; if (count !== 4'd15) begin n_fail++; $display("FAIL max_nowrap: got %0d want 15", count); end
   endtask

   task automatic test_rst_mid();
      do_reset();
      do_cfg(4'd5, 1'b0);
      do_start();
      tick(); tick(); tick();
      n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL rstmid_pre: got %0d want 3", count); end
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++; if (count !== 4'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got cnt=%0d busy=%b rdy=%b done=%b want 0 0 1 0", count, busy, cfg_ready, done); end
      start = 1'b1; tick(); tick(); start = 1'b0;
      n_checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL rstmid_start_ignored: got busy=%b rdy=%b cnt=%0d want 0 1 0", busy, cfg_ready, count); end
      // reset on the terminal edge drops the tc pulse
      do_cfg(4'd1, 1'b0);
      do_start();
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++; if (tc !== 1'b0 || done !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL rst_drops_tc: got tc=%b done=%b cnt=%0d want 0 0 0", tc, done, count); end
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_period = 4'd0; cfg_mode = 1'b0;
      start = 1'b0; halt = 1'b0;
      test_reset();
      test_oneshot();
      test_periodic();
      test_halt();
      test_cfg_handshake();
      test_period_bounds();
      test_rst_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
